// File: rtl/flash_read_seq.sv
// ---------------------------------------------------------------------------
// flash_read_seq
//
// Drives a hard SPI unit through its 8-bit system bus to run SPI-flash READ
// (0x03) commands. After reset it programs the unit (CSR, CR1, CR2, BR) and
// then accepts read commands. Each byte exchange polls SR for TRDY, writes
// TXDR, polls SR for RRDY and reads RXDR. The four header bytes (0x03 and a
// 24-bit address) are exchanged first and their receive bytes are dropped.
// Each data byte is then presented on the read stream. At most one byte is
// in flight at any time.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o     read command handshake (ready only in IDLE)
//   cmd_addr_i [23:0]             flash byte address
//   cmd_len_i  [15:0]             number of bytes to read (0 = header only)
//   rd_valid_o / rd_ready_i       read data stream handshake
//   rd_data_o  [7:0]              read data byte
//   busy_o                        high whenever the FSM is not in IDLE
//   err_o                         sticky bus ack-timeout flag
//   sb_stb_o, sb_rw_o (1=write)   system bus strobe and direction
//   sb_adr_o, sb_dat_o [7:0]      system bus address and write data
//   sb_dat_i [7:0], sb_ack_i      system bus read data and acknowledge
// ---------------------------------------------------------------------------
module flash_read_seq #(
  parameter logic [3:0] BUS_ADDR74  = 4'b0010,
  parameter logic [7:0] CLK_DIV     = 8'd1,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [23:0] cmd_addr_i,
  input  logic [15:0] cmd_len_i,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic [7:0]  rd_data_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        sb_stb_o,
  output logic        sb_rw_o,
  output logic [7:0]  sb_adr_o,
  output logic [7:0]  sb_dat_o,
  input  logic [7:0]  sb_dat_i,
  input  logic        sb_ack_i
);

  // Register offsets inside the SPI unit's bus window
  localparam logic [3:0] REG_CR1  = 4'h9;
  localparam logic [3:0] REG_CR2  = 4'hA;
  localparam logic [3:0] REG_BR   = 4'hB;
  localparam logic [3:0] REG_SR   = 4'hC;
  localparam logic [3:0] REG_TXDR = 4'hD;
  localparam logic [3:0] REG_RXDR = 4'hE;
  localparam logic [3:0] REG_CSR  = 4'hF;

  // Ack timer counts 0 .. ACK_TIMEOUT-1 while the strobe is waiting
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    INIT_CSR = 4'd0,
    INIT_CR1 = 4'd1,
    INIT_CR2 = 4'd2,
    INIT_BR  = 4'd3,
    IDLE     = 4'd4,
    CS_ON    = 4'd5,
    POLL_T   = 4'd6,
    WR_TX    = 4'd7,
    POLL_R   = 4'd8,
    RD_RX    = 4'd9,
    OUT      = 4'd10,
    CS_OFF   = 4'd11
  } state_t;

  state_t          state_r;
  logic [23:0]     addr_r;
  logic [15:0]     rem_r;
  logic [2:0]      hdr_cnt_r;
  logic [TW-1:0]   timer_r;

  logic            stb_r;
  logic            rw_r;
  logic [7:0]      adr_r;
  logic [7:0]      dat_r;
  logic            cmd_ready_r;
  logic            rd_valid_r;
  logic [7:0]      rd_data_r;
  logic            busy_r;
  logic            err_r;

  logic [7:0]      tx_byte_s;
  logic            acc_rw_s;
  logic [3:0]      acc_reg_s;
  logic [7:0]      acc_dat_s;

  assign cmd_ready_o = cmd_ready_r;
  assign rd_valid_o  = rd_valid_r;
  assign rd_data_o   = rd_data_r;
  assign busy_o      = busy_r;
  assign err_o       = err_r;
  assign sb_stb_o    = stb_r;
  assign sb_rw_o     = rw_r;
  assign sb_adr_o    = adr_r;
  assign sb_dat_o    = dat_r;

  // Byte to transmit: READ opcode and address MSB-first, then dummy zeros
  always_comb begin
    tx_byte_s = 8'h00;
    case (hdr_cnt_r)
      3'd0:    tx_byte_s = 8'h03;
      3'd1:    tx_byte_s = addr_r[23:16];
      3'd2:    tx_byte_s = addr_r[15:8];
      3'd3:    tx_byte_s = addr_r[7:0];
      default: tx_byte_s = 8'h00;
    endcase
  end

  // Bus access each state performs; latched into the outputs when issued
  always_comb begin
    acc_rw_s  = 1'b0;
    acc_reg_s = REG_SR;
    acc_dat_s = 8'h00;
    case (state_r)
      INIT_CSR: begin acc_rw_s = 1'b1; acc_reg_s = REG_CSR;  acc_dat_s = 8'h0F; end
      INIT_CR1: begin acc_rw_s = 1'b1; acc_reg_s = REG_CR1;  acc_dat_s = 8'h80; end
      INIT_CR2: begin acc_rw_s = 1'b1; acc_reg_s = REG_CR2;  acc_dat_s = 8'hC0; end
      INIT_BR:  begin acc_rw_s = 1'b1; acc_reg_s = REG_BR;   acc_dat_s = CLK_DIV; end
      CS_ON:    begin acc_rw_s = 1'b1; acc_reg_s = REG_CSR;  acc_dat_s = 8'h0E; end
      POLL_T:   begin acc_rw_s = 1'b0; acc_reg_s = REG_SR;   acc_dat_s = 8'h00; end
      WR_TX:    begin acc_rw_s = 1'b1; acc_reg_s = REG_TXDR; acc_dat_s = tx_byte_s; end
      POLL_R:   begin acc_rw_s = 1'b0; acc_reg_s = REG_SR;   acc_dat_s = 8'h00; end
      RD_RX:    begin acc_rw_s = 1'b0; acc_reg_s = REG_RXDR; acc_dat_s = 8'h00; end
      CS_OFF:   begin acc_rw_s = 1'b1; acc_reg_s = REG_CSR;  acc_dat_s = 8'h0F; end
      default:  begin acc_rw_s = 1'b0; acc_reg_s = REG_SR;   acc_dat_s = 8'h00; end
    endcase
  end

  // Main sequencer: state, bus strobe/timeout handling and all registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= INIT_CSR;
      addr_r      <= 24'h000000;
      rem_r       <= 16'h0000;
      hdr_cnt_r   <= 3'd0;
      timer_r     <= '0;
      stb_r       <= 1'b0;
      rw_r        <= 1'b0;
      adr_r       <= 8'h00;
      dat_r       <= 8'h00;
      cmd_ready_r <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_data_r   <= 8'h00;
      busy_r      <= 1'b1;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_r) begin
            addr_r      <= cmd_addr_i;
            rem_r       <= cmd_len_i;
            hdr_cnt_r   <= 3'd0;
            err_r       <= 1'b0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= CS_ON;
          end
        end

        OUT: begin
          // Next TX waits for the consumer, so only one byte is ever in flight
          if (rd_ready_i) begin
            rd_valid_r <= 1'b0;
            if (rem_r != 16'h0000) begin
              rem_r <= rem_r - 16'h0001;
            end
            if (rem_r <= 16'h0001) begin
              state_r <= CS_OFF;
            end else begin
              state_r <= POLL_T;
            end
          end
        end

        INIT_CSR, INIT_CR1, INIT_CR2, INIT_BR, CS_ON,
        POLL_T, WR_TX, POLL_R, RD_RX, CS_OFF: begin
          if (!stb_r) begin
            // Strobe is low here for at least the cycle after the last ack,
            // which provides the mandatory idle cycle between accesses.
            stb_r   <= 1'b1;
            rw_r    <= acc_rw_s;
            adr_r   <= {BUS_ADDR74, acc_reg_s};
            dat_r   <= acc_dat_s;
            timer_r <= '0;
          end else if (sb_ack_i) begin
            stb_r <= 1'b0;
            case (state_r)
              INIT_CSR: state_r <= INIT_CR1;
              INIT_CR1: state_r <= INIT_CR2;
              INIT_CR2: state_r <= INIT_BR;
              INIT_BR: begin
                state_r     <= IDLE;
                cmd_ready_r <= 1'b1;
                busy_r      <= 1'b0;
              end
              CS_ON:    state_r <= POLL_T;
              POLL_T: begin
                // Re-poll (same state) until TRDY; no retry limit
                if (sb_dat_i[4]) begin
                  state_r <= WR_TX;
                end
              end
              WR_TX:    state_r <= POLL_R;
              POLL_R: begin
                if (sb_dat_i[3]) begin
                  state_r <= RD_RX;
                end
              end
              RD_RX: begin
                if (hdr_cnt_r < 3'd4) begin
                  // Header receive bytes are discarded
                  hdr_cnt_r <= hdr_cnt_r + 3'd1;
                  if ((hdr_cnt_r == 3'd3) && (rem_r == 16'h0000)) begin
                    state_r <= CS_OFF;
                  end else begin
                    state_r <= POLL_T;
                  end
                end else begin
                  rd_data_r  <= sb_dat_i;
                  rd_valid_r <= 1'b1;
                  state_r    <= OUT;
                end
              end
              CS_OFF: begin
                state_r     <= IDLE;
                cmd_ready_r <= 1'b1;
                busy_r      <= 1'b0;
              end
              default: state_r <= INIT_CSR;
            endcase
          end else if (timer_r == TMO_LAST) begin
            // Ack timeout: abandon the access, deselect the flash, report error.
            // A timeout on the deselect write itself goes straight to IDLE.
            stb_r <= 1'b0;
            err_r <= 1'b1;
            if (state_r == CS_OFF) begin
              state_r     <= IDLE;
              cmd_ready_r <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              state_r <= CS_OFF;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end

        default: begin
          state_r     <= INIT_CSR;
          stb_r       <= 1'b0;
          cmd_ready_r <= 1'b0;
          rd_valid_r  <= 1'b0;
          busy_r      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_seq.sv
// ---------------------------------------------------------------------------
// tb_flash_read_seq
//
// Directed bench for flash_read_seq. A bus model acks every access one cycle
// after the strobe is seen (or never, for one chosen access). It returns
// SR=0x18 and an incrementing RXDR sequence starting at 0xA0 per command.
// It logs every acked write as {adr,dat}.
// ---------------------------------------------------------------------------
module tb_flash_read_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [23:0] cmd_addr = 24'h000000;
  logic [15:0] cmd_len = 16'h0000;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [7:0]  rd_data;
  logic        busy;
  logic        err;
  logic        sb_stb;
  logic        sb_rw;
  logic [7:0]  sb_adr;
  logic [7:0]  sb_wdat;
  logic [7:0]  sb_rdat;
  logic        sb_ack;

  int n_cmp = 0;
  int n_mis = 0;

  flash_read_seq dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .rd_data_o   (rd_data),
    .busy_o      (busy),
    .err_o       (err),
    .sb_stb_o    (sb_stb),
    .sb_rw_o     (sb_rw),
    .sb_adr_o    (sb_adr),
    .sb_dat_o    (sb_wdat),
    .sb_dat_i    (sb_rdat),
    .sb_ack_i    (sb_ack)
  );

  always #5 clk = ~clk;

  // ---------------- bus model ----------------
  logic        drop_mode = 1'b0;
  logic        stb_q;
  logic        prev_hit;
  logic [16:0] prev_bus;
  logic [7:0]  rx_cnt;
  int          acc_num;
  int          cur_acc;
  int          hi_cnt;
  int          to_len = 0;
  int          txw_cnt = 0;
  int          rdv_cnt = 0;
  int          prot_err = 0;
  logic [15:0] wlog[$];

  assign cur_acc = (sb_stb && !stb_q) ? acc_num + 1 : acc_num;
  assign sb_rdat = (sb_adr[3:0] == 4'hC) ? 8'h18 :
                   (sb_adr[3:0] == 4'hE) ? (8'hA0 + rx_cnt) : 8'h00;

  // Bus responder, write logger and protocol watcher
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_ack   <= 1'b0;
      stb_q    <= 1'b0;
      prev_hit <= 1'b0;
      prev_bus <= 17'h0;
      rx_cnt   <= 8'h00;
      acc_num  <= 0;
      hi_cnt   <= 0;
    end else begin
      stb_q    <= sb_stb;
      prev_bus <= {sb_rw, sb_adr, sb_wdat};
      prev_hit <= sb_stb && sb_ack;
      sb_ack   <= sb_stb && !sb_ack && !(drop_mode && (cur_acc == 3));
      if (cmd_valid && cmd_ready) begin
        acc_num <= 0;
        rx_cnt  <= 8'h00;
      end else if (sb_stb && !stb_q) begin
        acc_num <= acc_num + 1;
      end
      if (sb_stb) hi_cnt <= hi_cnt + 1;
      else        hi_cnt <= 0;
      if (!sb_stb && stb_q && !prev_hit) to_len <= hi_cnt;
      if ((sb_stb && stb_q && ({sb_rw, sb_adr, sb_wdat} != prev_bus)) || (prev_hit && sb_stb))
        prot_err <= prot_err + 1;
      if (sb_stb && sb_ack) begin
        if (sb_rw) begin
          wlog.push_back({sb_adr, sb_wdat});
          if (sb_adr[3:0] == 4'hD) txw_cnt <= txw_cnt + 1;
        end else if (sb_adr[3:0] == 4'hE) begin
          rx_cnt <= rx_cnt + 8'h01;
        end
      end
      if (rd_valid) rdv_cnt <= rdv_cnt + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 400 && cmd_ready !== 1'b1; i++) @(negedge clk);
    check_eq(tag, {31'h0, cmd_ready}, 32'h1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 400 && rd_valid !== 1'b1; i++) @(negedge clk);
    check_eq(tag, {31'h0, rd_valid}, 32'h1);
  endtask

  task automatic issue(input logic [23:0] addr, input logic [15:0] len);
    wait_ready("rdy_pre");
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [23:0] addr, input int len, input int stall_k, input bit chk_err);
    int tx0;
    logic [7:0] e;
    tx0 = txw_cnt;
    issue(addr, len[15:0]);
    check_eq("busy_cmd", {31'h0, busy}, 32'h1);
    if (chk_err) check_eq("err_clr", {31'h0, err}, 32'h0);
    for (int k = 0; k < len; k++) begin
      e = 8'hA4 + 8'(k);
      wait_valid("rdv_wait");
      check_eq("rd_data", {24'h0, rd_data}, {24'h0, e});
      check_eq("tx_inflt", txw_cnt - tx0, 5 + k);
      if (k == stall_k) begin
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          check_eq("hold_dat", {23'h0, rd_valid, rd_data}, {23'h0, 1'b1, e});
        end
        check_eq("hold_tx", txw_cnt - tx0, 5 + k);
      end
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
    wait_ready("rdy_post");
  endtask

  logic [15:0] exp2 [9] = '{16'h2F0E, 16'h2D03, 16'h2D12, 16'h2D34, 16'h2D56,
                            16'h2D00, 16'h2D00, 16'h2D00, 16'h2F0F};

  // ---------------- directed sequence ----------------
  initial begin
    int w0;
    int t0;
    int r0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_out", {busy, cmd_ready, sb_stb, sb_rw, err, rd_valid},
             {1'b1, 5'b00000});
    check_eq("rst_bus", {sb_adr, sb_wdat, rd_data}, 24'h000000);

    // Init sequence
    w0 = wlog.size();
    rst = 1'b0;
    wait_ready("init_rdy");
    check_eq("init_n", wlog.size() - w0, 4);
    check_eq("init_0", wlog[w0],     16'h2F0F);
    check_eq("init_1", wlog[w0 + 1], 16'h2980);
    check_eq("init_2", wlog[w0 + 2], 16'h2AC0);
    check_eq("init_3", wlog[w0 + 3], 16'h2B01);
    check_eq("idle_bsy", {30'h0, busy, err}, 32'h0);

    // Basic 3-byte read
    w0 = wlog.size();
    run_cmd(24'h123456, 3, -1, 1'b0);
    check_eq("rd3_n", wlog.size() - w0, 9);
    for (int i = 0; i < 9; i++) check_eq("rd3_wr", wlog[w0 + i], exp2[i]);

    // Backpressure on byte 2
    run_cmd(24'h123456, 3, 1, 1'b0);

    // Zero-length command: header only
    t0 = txw_cnt;
    r0 = rdv_cnt;
    w0 = wlog.size();
    run_cmd(24'h000100, 0, -1, 1'b0);
    check_eq("len0_tx", txw_cnt - t0, 4);
    check_eq("len0_rdv", rdv_cnt - r0, 0);
    check_eq("len0_cs", wlog[wlog.size() - 1], 16'h2F0F);

    // Ack timeout on the 3rd access (first TXDR write)
    drop_mode = 1'b1;
    t0 = txw_cnt;
    w0 = wlog.size();
    issue(24'h123456, 16'd2);
    wait_ready("to_idle");
    check_eq("to_err", {31'h0, err}, 32'h1);
    check_eq("to_len", to_len, 16);
    check_eq("to_tx", txw_cnt - t0, 0);
    check_eq("to_n", wlog.size() - w0, 2);
    check_eq("to_cs", wlog[wlog.size() - 1], 16'h2F0F);
    drop_mode = 1'b0;
    run_cmd(24'hABCDEF, 1, -1, 1'b1);

    // Reset during the data phase
    issue(24'h000010, 16'd3);
    wait_valid("mid_rdv");
    check_eq("mid_dat", {24'h0, rd_data}, 32'hA4);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst", {busy, cmd_ready, sb_stb, rd_valid, err}, {1'b1, 4'b0000});
    check_eq("mid_bus", {sb_adr, sb_wdat, rd_data}, 24'h000000);
    w0 = wlog.size();
    @(negedge clk);
    rst = 1'b0;
    wait_ready("mid_rdy");
    check_eq("mid_n", wlog.size() - w0, 4);
    check_eq("mid_cs", wlog[w0], 16'h2F0F);
    check_eq("mid_cr1", wlog[w0 + 1], 16'h2980);

    check_eq("bus_prot", prot_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/flash_read_seq.md
FLASH_READ_SEQ -- requirements
Module: flash_read_seq

Interface
REQ-001 The block SHALL have parameter BUS_ADDR74, default 4'b0010, meaning the upper address nibble of the hard SPI unit's system bus.
REQ-002 The block SHALL have parameter CLK_DIV, default 8'd1, meaning the value written to SPIBR (SCK = clk/(CLK_DIV+1)).
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 16, meaning the maximum cycles sb_stb_o waits for sb_ack_i.
REQ-004 clk_i  in  1  system clock; all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid_i / cmd_ready_o  in/out  1 / 1  read-command handshake.
REQ-007 cmd_addr_i  in  24  flash byte address; cmd_len_i  in  16  byte count.
REQ-008 rd_valid_o / rd_ready_i  out/in  1 / 1  read-data stream handshake; rd_data_o  out  8  flash byte.
REQ-009 busy_o  out  1  high whenever the FSM is not in IDLE; err_o  out  1  sticky bus-timeout flag.
REQ-010 sb_stb_o, sb_rw_o (1=write)  out  1 each; sb_adr_o  out  8; sb_dat_o  out  8.
REQ-011 sb_dat_i  in  8; sb_ack_i  in  1.

Function
REQ-012 sb_adr_o SHALL always be {BUS_ADDR74, reg}, with reg one of: CR1=4'h9, CR2=4'hA, BR=4'hB, SR=4'hC, TXDR=4'hD, RXDR=4'hE, CSR=4'hF.
REQ-013 Bus access: the block SHALL hold sb_stb_o, sb_rw_o, sb_adr_o and sb_dat_o stable until sb_ack_i is sampled high, drop sb_stb_o the next cycle, and leave at least one idle cycle between accesses.
REQ-014 Read data SHALL be captured from sb_dat_i in the cycle sb_ack_i is high.
REQ-015 If sb_ack_i is not seen within ACK_TIMEOUT cycles of sb_stb_o rising, the block SHALL drop sb_stb_o, set err_o, write CSR=8'h0F, and go to IDLE.
REQ-016 FSM states: INIT_CSR, INIT_CR1, INIT_CR2, INIT_BR, IDLE, CS_ON, POLL_T, WR_TX, POLL_R, RD_RX, OUT, CS_OFF.
REQ-017 Init sequence after reset, in order: CSR<=8'h0F, CR1<=8'h80, CR2<=8'hC0, BR<=CLK_DIV, then IDLE.
REQ-018 cmd_ready_o SHALL be high only in IDLE; on cmd_valid_i&&cmd_ready_o the block SHALL latch addr/len, clear err_o, and enter CS_ON.
REQ-019 CS_ON SHALL write CSR<=8'h0E, asserting chip select 0.
REQ-020 Per byte, the block SHALL: poll SR until bit4 (TRDY) is 1; write TXDR; poll SR until bit3 (RRDY) is 1; read RXDR.
REQ-021 Header bytes SHALL be sent in this order: 8'h03, addr[23:16], addr[15:8], addr[7:0]; their RXDR bytes are discarded.
REQ-022 Data phase SHALL transmit 8'h00 per byte, cmd_len_i bytes total, with each RXDR byte presented in OUT.
REQ-023 In OUT, rd_valid_o SHALL be high and rd_data_o stable until rd_ready_i; the next TX SHALL not start before the handshake, giving at most one byte in flight.
REQ-024 cmd_len_i==0 SHALL send the header only, with no rd_valid_o pulse.
REQ-025 After the last byte, CS_OFF SHALL write CSR<=8'h0F and return to IDLE.
REQ-026 The 16-bit remaining-byte counter SHALL decrement on each OUT handshake; the block SHALL never wrap it below zero.
REQ-027 SR polling SHALL have no retry limit; only the per-access ack timeout applies.
REQ-028 cmd_valid_i outside IDLE SHALL be ignored.

Reset
REQ-029 On rst_i high, immediately: state=INIT_CSR; sb_stb_o=0, sb_rw_o=0, sb_adr_o=0, sb_dat_o=0, cmd_ready_o=0, rd_valid_o=0, rd_data_o=0, busy_o=1, err_o=0; counters 0.
REQ-030 Reset mid-transfer SHALL discard the command; the init sequence SHALL deassert CS before any new command, because the hard SPI unit is not reset by rst_i.

Verification
REQ-031 Release reset with a 1-cycle-ack bus model -> writes observed: F:0F, 9:80, A:C0, B:01 (addr nibble 2), then cmd_ready_o=1.
REQ-032 Cmd addr=24'h123456, len=3, SR always 8'h18, RXDR returns 8'hA0,8'hA1,... -> TX: 03,12,34,56,00,00,00; stream outputs A4,A5,A6; CSR 0E before the first TX and 0F after the last.
REQ-033 Same command with rd_ready_i low 10 cycles on byte 2 -> rd_data_o held, no TXDR write until the handshake.
REQ-034 len=0 -> exactly 4 TXDR writes, rd_valid_o never high, back to IDLE.
REQ-035 Bus model never acks the 3rd access of a command -> sb_stb_o drops after 16 cycles, err_o=1, CSR<=0F, IDLE; err_o clears on the next accepted command.
REQ-036 Assert rst_i during the data phase -> outputs at reset values in the same cycle; after release, the init sequence begins with CSR<=0F.
